// File: rtl/seq_mult_if.sv
// Request/response bundle for the shared shift-add multiplier.
// The master presents operands with a start strobe; the slave reports busy, done and the product.
interface seq_mult_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     m_in;
    logic [WIDTH-1:0]     n_in;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   prod;

    modport master (output start, m_in, n_in, input busy, done, prod);
    modport slave  (input start, m_in, n_in, output busy, done, prod);
endinterface

// File: rtl/seq_mult.sv
// Parametrised shift-add sequential multiplier with optional two's-complement mode.
// Operands are multiplied as magnitudes; the sign is applied by a final negate step.
module seq_mult #(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input logic         clk,
    input logic         rst_n,
    seq_mult_if.slave   bus
);
    localparam int IW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        LOOP   = 3'd2,
        ADD    = 3'd3,
        SHIFT  = 3'd4,
        NEG    = 3'd5,
        FINISH = 3'd6
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [PW-1:0]    m;
    logic [WIDTH-1:0] n;
    logic [IW-1:0]    i;
    logic             neg;
    logic [PW-1:0]    prod_r;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // The most negative operand maps onto magnitude 2^(WIDTH-1), which still fits unsigned.
    assign a_mag = (SIGNED && a_r[WIDTH-1]) ? (~a_r + WIDTH'(1)) : a_r;
    assign b_mag = (SIGNED && b_r[WIDTH-1]) ? (~b_r + WIDTH'(1)) : b_r;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: state_nx gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = bus.start ? INIT : IDLE;
            INIT:    state_nx = LOOP;
            LOOP: begin
                if (i == '0 || n == '0) state_nx = neg ? NEG : FINISH;
                else if (n[0])          state_nx = ADD;
                else                    state_nx = SHIFT;
            end
            ADD:     state_nx = SHIFT;
            SHIFT:   state_nx = LOOP;
            NEG:     state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: every datapath register is reset, so an aborted multiply leaves prod reading zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            m      <= '0;
            n      <= '0;
            i      <= '0;
            neg    <= 1'b0;
            prod_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r <= bus.m_in;
                        b_r <= bus.n_in;
                    end
                end
                INIT: begin
                    prod_r <= '0;
                    i      <= IW'(WIDTH);
                    m      <= {{WIDTH{1'b0}}, a_mag};
                    n      <= b_mag;
                    neg    <= SIGNED && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                end
                ADD:   prod_r <= prod_r + m;
                SHIFT: begin
                    m <= m << 1;
                    n <= n >> 1;
                    i <= i - IW'(1);
                end
                NEG:   prod_r <= ~prod_r + PW'(1);
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == FINISH);
    assign bus.prod = prod_r;
endmodule
